// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: d = a - b - bin over WIDTH bits, one bit per clock,
// LSB first, built around a single full-subtractor cell. A start/busy/done
// handshake lets a sequencer issue operations back to back; results (d, bout,
// ovf) are registered and only change on the completion edge.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf
);

    localparam int              CW     = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   LAST   = CW'(WIDTH - 1);
    localparam logic [CW-1:0]   PENULT = CW'(WIDTH - 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Operand shift registers, consumed from bit 0 upwards.
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    // Partial result: the WIDTH-1 most recently produced difference bits.
    // The final bit is merged in combinationally on the completion edge, so
    // the register never needs to hold the full word.
    logic [WIDTH-2:0] res_sr;
    logic [WIDTH-1:0] res_nxt;

    logic             borrow;
    logic             msb_borrow;
    logic [CW-1:0]    cnt;

    logic             x;
    logic             y;
    logic             r;
    logic             diff_bit;
    logic             borrow_nxt;
    logic             accept;
    logic             in_shift;
    logic             last_bit;
    logic             penult_bit;

    // Full-subtractor cell and handshake qualifiers for the current cycle.
    always_comb begin
        x          = a_sr[0];
        y          = b_sr[0];
        r          = borrow;
        diff_bit   = x ^ y ^ r;
        borrow_nxt = (~x & y) | (~(x ^ y) & r);
        res_nxt    = {diff_bit, res_sr};
        in_shift   = (state == SHIFT);
        accept     = start && !in_shift;
        last_bit   = in_shift && (cnt == LAST);
        penult_bit = in_shift && (cnt == PENULT);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: start is honoured in IDLE and in DONE, never in SHIFT.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = start ? SHIFT : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            SHIFT:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Operand capture and per-bit datapath shifting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            borrow     <= 1'b0;
            msb_borrow <= 1'b0;
            cnt        <= '0;
        end else if (accept) begin
            a_sr       <= a;
            b_sr       <= b;
            res_sr     <= '0;
            borrow     <= bin;
            msb_borrow <= 1'b0;
            cnt        <= '0;
        end else if (in_shift) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= res_nxt[WIDTH-1:1];
            borrow <= borrow_nxt;
            cnt    <= cnt + CW'(1);
            if (penult_bit) begin
                msb_borrow <= borrow_nxt;
            end
        end
    end

    // Result registers: loaded only on the edge that processes the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d    <= '0;
            bout <= 1'b0;
            ovf  <= 1'b0;
        end else if (last_bit) begin
            d    <= res_nxt;
            bout <= borrow_nxt;
            ovf  <= msb_borrow ^ borrow_nxt;
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=4 and WIDTH=8.
// Expected results come from integer arithmetic on the operands.
module tb_serial_subtractor;

    logic       clk;
    logic       rst_n;

    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       bin4;
    logic       busy4;
    logic       done4;
    logic [3:0] d4;
    logic       bout4;
    logic       ovf4;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       bin8;
    logic       busy8;
    logic       done8;
    logic [7:0] d8;
    logic       bout8;
    logic       ovf8;

    int n_checks = 0;
    int n_pass   = 0;

    // Last completed result per DUT (index 0: WIDTH=4, index 1: WIDTH=8).
    logic [7:0] pd [2];
    logic       pb [2];
    logic       po [2];

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .bin   (bin4),
        .busy  (busy4),
        .done  (done4),
        .d     (d4),
        .bout  (bout4),
        .ovf   (ovf4)
    );

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .bin   (bin8),
        .busy  (busy8),
        .done  (done8),
        .d     (d8),
        .bout  (bout8),
        .ovf   (ovf8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Reference: plain integer subtraction, unsigned compare and signed range test.
    function automatic void model(input int w, input int ua, input int ub, input int ubin,
                                  output int ed, output int eb, output int eo);
        int m;
        int h;
        int sa;
        int sb;
        int sf;
        m  = 1 << w;
        h  = m >> 1;
        sa = (ua >= h) ? ua - m : ua;
        sb = (ub >= h) ? ub - m : ub;
        sf = sa - sb - ubin;
        ed = (((ua - ub - ubin) % m) + m) % m;
        eb = (ua < ub + ubin) ? 1 : 0;
        eo = (sf < -h || sf > h - 1) ? 1 : 0;
    endfunction

    task automatic drive(input int w, input logic [7:0] ia, input logic [7:0] ib,
                         input logic ibin, input logic st);
        if (w == 4) begin
            a4 = ia[3:0]; b4 = ib[3:0]; bin4 = ibin; start4 = st;
        end else begin
            a8 = ia; b8 = ib; bin8 = ibin; start8 = st;
        end
    endtask

    function automatic logic get_busy(input int w);
        return (w == 4) ? busy4 : busy8;
    endfunction

    function automatic logic get_done(input int w);
        return (w == 4) ? done4 : done8;
    endfunction

    function automatic logic [7:0] get_d(input int w);
        return (w == 4) ? {4'b0000, d4} : d8;
    endfunction

    function automatic logic get_bout(input int w);
        return (w == 4) ? bout4 : bout8;
    endfunction

    function automatic logic get_ovf(input int w);
        return (w == 4) ? ovf4 : ovf8;
    endfunction

    // Called at a negedge. Issues one operation, follows it to its done pulse
    // and returns at the negedge where done is high with start deasserted.
    // With noise set, start is held high with junk operands in cycles 1-3.
    task automatic run(input int w, input logic [7:0] ia_in, input logic [7:0] ib_in,
                       input logic ibin, input bit noise, input string tag);
        logic [7:0] mask;
        logic [7:0] ia;
        logic [7:0] ib;
        int ed;
        int eb;
        int eo;
        int n;
        int idx;
        bit seen;
        mask = (w == 4) ? 8'h0F : 8'hFF;
        ia   = ia_in & mask;
        ib   = ib_in & mask;
        idx  = (w == 4) ? 0 : 1;
        model(w, int'(ia), int'(ib), int'(ibin), ed, eb, eo);
        drive(w, ia, ib, ibin, 1'b1);
        @(negedge clk);
        n    = 0;
        seen = 1'b0;
        while (n < 40) begin
            if (get_done(w)) begin
                seen = 1'b1;
                break;
            end
            check({tag, "_busy"}, 32'(get_busy(w)), 32'd1);
            check({tag, "_hold"}, {get_d(w), 6'd0, get_bout(w), get_ovf(w)},
                  {pd[idx], 6'd0, pb[idx], po[idx]});
            if (noise && n < 3) begin
                drive(w, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
            end else begin
                drive(w, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
            end
            n++;
            @(negedge clk);
        end
        drive(w, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, 32'(n), 32'(w));
        check({tag, "_busy_at_done"}, 32'(get_busy(w)), 32'd0);
        check({tag, "_d"}, 32'(get_d(w)), 32'(ed));
        check({tag, "_bout"}, 32'(get_bout(w)), 32'(eb));
        check({tag, "_ovf"}, 32'(get_ovf(w)), 32'(eo));
        pd[idx] = 8'(ed);
        pb[idx] = 1'(eb);
        po[idx] = 1'(eo);
    endtask

    // One cycle after a done pulse with no new start: pulse gone, not busy.
    task automatic idle_after(input int w, input string tag);
        @(negedge clk);
        check({tag, "_pulse"}, 32'(get_done(w)), 32'd0);
        check({tag, "_idle"}, 32'(get_busy(w)), 32'd0);
    endtask

    initial begin
        bit   got_done;
        int   w;
        rst_n = 1'b0;
        drive(4, 8'd0, 8'd0, 1'b0, 1'b0);
        drive(8, 8'd0, 8'd0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            pd[i] = '0; pb[i] = 1'b0; po[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        check("reset4_outs", {busy4, done4, d4, bout4, ovf4}, 32'd0);
        check("reset8_outs", {busy8, done8, d8, bout8, ovf8}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run(4, 8'd6, 8'd3, 1'b0, 1'b0, "t6m3");
        idle_after(4, "t6m3");
        run(4, 8'd3, 8'd9, 1'b0, 1'b0, "t3m9");
        idle_after(4, "t3m9");
        run(4, 8'd0, 8'd0, 1'b1, 1'b0, "t0m0b");
        idle_after(4, "t0m0b");
        run(4, 8'd7, 8'd8, 1'b0, 1'b0, "t7m8");
        idle_after(4, "t7m8");
        run(4, 8'd8, 8'd1, 1'b0, 1'b0, "t8m1");
        idle_after(4, "t8m1");

        // start during busy ignored; then a new start in the DONE cycle
        // (the b2b latency of 4 after acceptance puts its done 5 cycles on).
        run(4, 8'd12, 8'd2, 1'b1, 1'b1, "noise");
        run(4, 8'd5, 8'd5, 1'b0, 1'b0, "b2b");
        idle_after(4, "b2b");

        // Leave a non-zero result in place so the reset clear is observable.
        run(4, 8'd8, 8'd1, 1'b0, 1'b0, "pre_rst");
        idle_after(4, "pre_rst");

        // Abort an operation with an asynchronous reset between clock edges.
        drive(4, 8'd2, 8'd1, 1'b0, 1'b1);
        @(negedge clk);
        drive(4, 8'd0, 8'd0, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("abort_outs", {busy4, done4, d4, bout4, ovf4}, 32'd0);
        pd[0] = '0; pb[0] = 1'b0; po[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        got_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done4 || busy4) got_done = 1'b1;
        end
        check("abort_no_done", 32'(got_done), 32'd0);
        run(4, 8'd9, 8'd4, 1'b1, 1'b0, "fresh");
        idle_after(4, "fresh");

        // Random regression on both widths, mixing idle gaps and back-to-back.
        for (int i = 0; i < 40; i++) begin
            w = (i < 20) ? 4 : 8;
            run(w, 8'($urandom), 8'($urandom), 1'($urandom), bit'($urandom_range(0, 1)), "rnd");
            if ($urandom_range(0, 1) == 1) begin
                idle_after(w, "rnd");
            end
        end
        idle_after(8, "final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
